i2c_arbiter: RTL and testbench
==============================

Name: i2c_arbiter

Overview:
- Shares one i2c_master between N_REQ independent requesters, e.g. a sensor poller, a DAC updater and a config loader.
- Arbitrates round-robin and latches the winner's transaction fields. Drives the master's enable/rw/slave_addr/data_in and sequences the master's busy/done handshake.
- Returns read data and completion/error status to the winner.
- Sits between the system-side requesters and the i2c_master instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 1024, clk cycles allowed between asserting m_enable and seeing m_busy high.
- RUN_TIMEOUT, 65536, clk cycles allowed between m_busy rising and m_busy falling.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level
- req_rw  in  N_REQ  per-requester direction: 0 = write, 1 = read
- req_addr  in  7*N_REQ  per-requester slave address; slice i = [7i+6:7i]
- req_wdata  in  12*N_REQ  per-requester 12-bit write data; slice i = [12i+11:12i]
- gnt  out  N_REQ  one-hot, single-cycle pulse: request i accepted and fields latched
- rsp_valid  out  N_REQ  one-hot, single-cycle pulse: transaction of requester i finished
- rsp_rdata  out  12  read data; valid with rsp_valid when latched rw=1
- rsp_err  out  1  timeout flag; valid with rsp_valid
- m_enable  out  1  to i2c_master enable
- m_rw  out  1  to i2c_master rw
- m_slave_addr  out  7  to i2c_master slave_addr
- m_data_in  out  12  to i2c_master data_in
- m_data_out  in  12  from i2c_master data_out
- m_busy  in  1  from i2c_master busy
- m_done  in  1  from i2c_master done; level, may span several clk cycles

Behaviour:
- Reset (async, rst_n low): state IDLE; gnt=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; m_enable=0; m_rw=0; m_slave_addr=0; m_data_in=0; rr pointer=0; timeout counter=0.
- Reset mid-transaction drops m_enable immediately. No response is issued for the aborted transaction.
- States: IDLE, WAIT_FREE, LAUNCH, RUN, RESP.
- IDLE:
  - If any req bit is set, pick the winner round-robin: search starts at the rr pointer, wrapping modulo N_REQ.
  - Latch the winner's rw/addr/wdata into the m_* registers and pulse gnt[winner] for exactly one cycle. Go to WAIT_FREE.
  - Latency: req high in cycle t gives gnt in cycle t+1 (registered).
  - Only req is sampled at arbitration. Fields must be stable in the cycle req is sampled. Bits dropped before that cycle are ignored.
- WAIT_FREE: stay while m_busy=1, covering a master still finishing after a prior timeout. When m_busy=0, go to LAUNCH.
- LAUNCH:
  - m_enable=1 (registered) and the timeout counter runs.
  - On m_busy=1: m_enable=0 in the next cycle, counter clears, go to RUN. Enable must be dropped so the master does not restart after STOP.
  - If the counter reaches START_TIMEOUT-1 first: m_enable=0, rsp_err=1, go to RESP.
- RUN:
  - Counter runs. m_done is ignored for sequencing; completion is m_busy falling (1 to 0).
  - On m_busy falling: capture m_data_out into rsp_rdata if the latched rw=1, otherwise leave rsp_rdata unchanged. Go to RESP.
  - If the counter reaches RUN_TIMEOUT-1 first: rsp_err=1, go to RESP. The next WAIT_FREE absorbs the still-busy master.
- RESP: pulse rsp_valid[winner] for one cycle with rsp_err. Set rr pointer = (winner+1) mod N_REQ. Go to IDLE.
- rsp_err returns to 0 on the next accepted grant.
- A requester may reassert req in the same cycle as its rsp_valid. It is served again only after all other pending requesters (fairness).
- Only one transaction is in flight; a pending req simply waits.
- Slave NACK is not visible to the master, so it is not reported. rsp_err means timeout only.
- Counter width: $clog2(max(START_TIMEOUT,RUN_TIMEOUT)). It saturates and never wraps.

Decomposition:
- Add to i2c_pkg: arb_state_t enum {IDLE, WAIT_FREE, LAUNCH, RUN, RESP}, plus ARB_ADDR_W=7 and ARB_DATA_W=12.
- One natural sub-module: i2c_rr_pick. It is combinational, takes req and pointer, and returns a one-hot winner plus an index. It is reusable for other shared buses.

Test Plan:
- Single write: req[0]=1, rw=0, addr=7'h48, wdata=12'hABC; slave model ACKs.
  Expect: gnt[0] one cycle after req; m_enable held until busy; m_data_in=12'hABC; rsp_valid[0] one cycle after busy falls; rsp_err=0.
- Single read: req[2], rw=1, addr=7'h50; slave returns 0xDE then 0xF0.
  Expect: rsp_rdata=12'hDEF with rsp_valid[2].
- Contention: req=4'b1111 held continuously.
  Expect: grant order 0,1,2,3,0; no requester granted twice before the others.
- Back-to-back: req[1] reasserted in the same cycle as its rsp_valid while req[3] is pending.
  Expect: next gnt is gnt[3].
- Start timeout: master model with busy tied 0, START_TIMEOUT=16.
  Expect: m_enable drops after 16 cycles; rsp_valid[i] with rsp_err=1; arbiter returns to IDLE.
- Reset mid-RUN: pull rst_n low while busy=1.
  Expect: all outputs 0 immediately; no rsp_valid after release. The next req waits in WAIT_FREE until busy=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C arbiter slice.
//   arb_state_t : arbiter FSM states
//   ARB_ADDR_W  : 7-bit I2C slave address width
//   ARB_DATA_W  : 12-bit transaction data width
//   max_int()   : elaboration-time helper for sizing counters
package i2c_pkg;

    localparam int ARB_ADDR_W = 7;
    localparam int ARB_DATA_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FREE,
        LAUNCH,
        RUN,
        RESP
    } arb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
//   req    in  N      request vector
//   ptr    in  IDX_W  index where the search starts (wraps modulo N)
//   onehot out N      one-hot winner (all zero when no request)
//   idx    out IDX_W  index of the winner (0 when no request)
//   any    out 1      at least one request is set
module i2c_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int               j;
        logic [IDX_W-1:0] j_idx;
        logic             found;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        j_idx  = '0;
        any    = |req;
        for (int k = 0; k < N; k++) begin
            // ptr < N always holds, so one subtraction is enough to wrap
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = IDX_W'(j);
            if (!found && req[j_idx]) begin
                found         = 1'b1;
                onehot[j_idx] = 1'b1;
                idx           = j_idx;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master between N_REQ requesters.
//   clk, rst_n                      clock, asynchronous active-low reset
//   req/req_rw/req_addr/req_wdata   per-requester request level and fields
//   gnt                             one-cycle pulse: request accepted
//   rsp_valid/rsp_rdata/rsp_err     one-cycle completion pulse, read data, timeout flag
//   m_enable/m_rw/m_slave_addr/m_data_in   drive the i2c_master
//   m_data_out/m_busy/m_done        from the i2c_master (m_done unused: completion is busy falling)
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 1024,
    parameter int RUN_TIMEOUT   = 65536
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             req_rw,
    input  logic [ARB_ADDR_W*N_REQ-1:0]  req_addr,
    input  logic [ARB_DATA_W*N_REQ-1:0]  req_wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [ARB_DATA_W-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         m_enable,
    output logic                         m_rw,
    output logic [ARB_ADDR_W-1:0]        m_slave_addr,
    output logic [ARB_DATA_W-1:0]        m_data_in,
    input  logic [ARB_DATA_W-1:0]        m_data_out,
    input  logic                         m_busy,
    input  logic                         m_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(max_int(START_TIMEOUT, RUN_TIMEOUT));
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [N_REQ-1:0] LSB_ONE    = N_REQ'(1);

    arb_state_t              state_q, state_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d;
    logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [ARB_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    m_enable_q, m_enable_d;
    logic                    m_rw_q, m_rw_d;
    logic [ARB_ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [ARB_DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        win_idx_q, win_idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q;

    logic [CNT_W-1:0]        cnt_inc;
    logic [N_REQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;

    logic [ARB_ADDR_W-1:0]   addr_arr  [N_REQ];
    logic [ARB_DATA_W-1:0]   wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ARB_ADDR_W +: ARB_ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*ARB_DATA_W +: ARB_DATA_W];
        end
    endgenerate

    i2c_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Saturating so a stuck counter can never wrap back under a timeout limit
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        m_enable_d  = m_enable_q;
        m_rw_d      = m_rw_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        rr_ptr_d    = rr_ptr_q;
        win_idx_d   = win_idx_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d     = pick_onehot;
                    win_idx_d = pick_idx;
                    m_rw_d    = req_rw[pick_idx];
                    m_addr_d  = addr_arr[pick_idx];
                    m_wdata_d = wdata_arr[pick_idx];
                    rsp_err_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                // Master may still be busy after a run timeout; do not enable it until idle
                cnt_d = '0;
                if (!m_busy) begin
                    m_enable_d = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                if (m_busy) begin
                    // Drop enable so the master does not restart after its STOP
                    m_enable_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = RUN;
                end else if (cnt_q == START_LAST) begin
                    m_enable_d  = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = LSB_ONE << win_idx_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (busy_q && !m_busy) begin
                    if (m_rw_q) begin
                        rsp_rdata_d = m_data_out;
                    end
                    rsp_valid_d = LSB_ONE << win_idx_q;
                    state_d     = RESP;
                end else if (cnt_q == RUN_LAST) begin
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = LSB_ONE << win_idx_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                rr_ptr_d = (win_idx_q == IDX_W'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            m_enable_q  <= 1'b0;
            m_rw_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            m_enable_q  <= m_enable_d;
            m_rw_q      <= m_rw_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
            win_idx_q   <= win_idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= m_busy;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign m_enable     = m_enable_q;
    assign m_rw         = m_rw_q;
    assign m_slave_addr = m_addr_q;
    assign m_data_in    = m_wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: stimulus pushes expected grants, launches
// and responses; a monitor and a master model pop and compare.
module tb_i2c_arbiter;

    localparam int N = 4;

    typedef struct {
        int          idx;
        logic        err;
        logic [11:0] rdata;
    } rsp_t;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [11:0] wdata;
    } launch_t;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  req_rw;
    logic [27:0]   req_addr;
    logic [47:0]   req_wdata;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rsp_valid;
    logic [11:0]   rsp_rdata;
    logic          rsp_err;
    logic          m_enable;
    logic          m_rw;
    logic [6:0]    m_slave_addr;
    logic [11:0]   m_data_in;
    logic [11:0]   m_data_out;
    logic          m_busy;
    logic          m_done;

    logic [6:0]    f_addr  [N];
    logic [11:0]   f_wdata [N];

    int n_cmp = 0;
    int n_bad = 0;

    int      exp_gnt[$];
    rsp_t    exp_rsp[$];
    launch_t exp_launch[$];

    logic dead         = 1'b0;
    logic hang         = 1'b0;
    logic hang_release = 1'b0;
    int   run_len      = 6;

    generate
        for (genvar g = 0; g < N; g++) begin : g_pack
            assign req_addr[g*7 +: 7]    = f_addr[g];
            assign req_wdata[g*12 +: 12] = f_wdata[g];
        end
    endgenerate

    i2c_arbiter #(
        .N_REQ         (N),
        .START_TIMEOUT (16),
        .RUN_TIMEOUT   (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .m_enable     (m_enable),
        .m_rw         (m_rw),
        .m_slave_addr (m_slave_addr),
        .m_data_in    (m_data_in),
        .m_data_out   (m_data_out),
        .m_busy       (m_busy),
        .m_done       (m_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic rw, input logic [6:0] a, input logic [11:0] d);
        req_rw[2'(i)]  = rw;
        f_addr[2'(i)]  = a;
        f_wdata[2'(i)] = d;
    endtask

    task automatic push_txn(input int i, input logic rw, input logic [6:0] a, input logic [11:0] d,
                            input logic err, input logic [11:0] rd, input bit do_launch, input bit do_rsp);
        launch_t l;
        rsp_t    r;
        l.addr = a; l.rw = rw; l.wdata = d;
        r.idx = i; r.err = err; r.rdata = rd;
        exp_gnt.push_back(i);
        if (do_launch) exp_launch.push_back(l);
        if (do_rsp) exp_rsp.push_back(r);
    endtask

    task automatic wait_gnt(input int i, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!gnt[2'(i)] && lat < 500);
        chk($sformatf("wait_gnt%0d", i), 32'(gnt[2'(i)]), 1);
    endtask

    task automatic wait_rsp(input int i);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rsp_valid[2'(i)] && c < 500);
        chk($sformatf("wait_rsp%0d", i), 32'(rsp_valid[2'(i)]), 1);
    endtask

    task automatic drain();
        int c = 0;
        while ((exp_gnt.size() != 0 || exp_rsp.size() != 0 || exp_launch.size() != 0) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("drain_timeout", 32'(c >= 1000), 0);
        repeat (3) @(negedge clk);
    endtask

    // Issue one request from IDLE; checks the one-cycle grant latency
    task automatic single(input int i, input logic rw, input logic [6:0] a, input logic [11:0] d,
                          input logic err, input logic [11:0] rd, input bit do_launch);
        int lat;
        set_fields(i, rw, a, d);
        push_txn(i, rw, a, d, err, rd, do_launch, 1'b1);
        req[2'(i)] = 1'b1;
        wait_gnt(i, lat);
        chk($sformatf("gnt_latency%0d", i), 32'(lat), 1);
        req[2'(i)] = 1'b0;
    endtask

    // Monitor: compares every grant and response pulse against the queues
    initial begin
        int   e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (gnt != '0) begin
                    if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
                    else begin
                        e = exp_gnt.pop_front();
                        chk("gnt", 32'(gnt), 32'(1) << e);
                    end
                end
                if (rsp_valid != '0) begin
                    $display("[%0t] rsp valid=%b err=%0b rdata=%h", $time, rsp_valid, rsp_err, rsp_rdata);
                    if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
                    else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'(1) << r.idx);
                        chk("rsp_err", 32'(rsp_err), 32'(r.err));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                    end
                end
            end
        end
    end

    // i2c_master model: busy rises 2 cycles after enable, lasts run_len cycles
    initial begin
        launch_t e;
        logic    cur_rw;
        logic    cur_hang;
        int      guard;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_data_out = 12'h000;
        forever begin
            @(negedge clk);
            if (rst_n && !dead && m_enable && !m_busy) begin
                cur_rw   = m_rw;
                cur_hang = hang;
                if (exp_launch.size() == 0) chk("launch_unexpected", 1, 0);
                else begin
                    e = exp_launch.pop_front();
                    chk("m_slave_addr", 32'(m_slave_addr), 32'(e.addr));
                    chk("m_rw", 32'(m_rw), 32'(e.rw));
                    chk("m_data_in", 32'(m_data_in), 32'(e.wdata));
                end
                repeat (2) @(negedge clk);
                chk("m_enable_held", 32'(m_enable), 1);
                m_busy = 1'b1;
                @(negedge clk);
                chk("m_enable_dropped", 32'(m_enable), 0);
                if (cur_hang) begin
                    guard = 0;
                    while (!hang_release && guard < 5000) begin
                        @(negedge clk);
                        guard++;
                    end
                end else begin
                    repeat (run_len) @(negedge clk);
                end
                m_data_out = cur_rw ? 12'hDEF : 12'h5A5;
                m_busy = 1'b0;
                m_done = 1'b1;
                repeat (2) @(negedge clk);
                m_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int en_cnt;
        rst_n = 1'b0;
        req = '0;
        req_rw = '0;
        for (int i = 0; i < N; i++) begin
            f_addr[i]  = '0;
            f_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_m_enable", 32'(m_enable), 0);
        chk("rst_m_fields", {m_rw, m_slave_addr, m_data_in}, 0);
        repeat (2) @(negedge clk);

        // Single write, single read, then a write that moves rr back to 0
        single(0, 1'b0, 7'h48, 12'hABC, 1'b0, 12'h000, 1'b1);
        drain();
        single(2, 1'b1, 7'h50, 12'h000, 1'b0, 12'hDEF, 1'b1);
        drain();
        single(3, 1'b0, 7'h22, 12'h123, 1'b0, 12'hDEF, 1'b1);
        drain();

        // Contention: all four held; order 0,1,2,3,0
        set_fields(0, 1'b0, 7'h10, 12'h100);
        set_fields(1, 1'b0, 7'h11, 12'h111);
        set_fields(2, 1'b0, 7'h12, 12'h122);
        set_fields(3, 1'b0, 7'h13, 12'h133);
        push_txn(0, 1'b0, 7'h10, 12'h100, 1'b0, 12'hDEF, 1'b1, 1'b1);
        push_txn(1, 1'b0, 7'h11, 12'h111, 1'b0, 12'hDEF, 1'b1, 1'b1);
        push_txn(2, 1'b0, 7'h12, 12'h122, 1'b0, 12'hDEF, 1'b1, 1'b1);
        push_txn(3, 1'b0, 7'h13, 12'h133, 1'b0, 12'hDEF, 1'b1, 1'b1);
        push_txn(0, 1'b0, 7'h10, 12'h100, 1'b0, 12'hDEF, 1'b1, 1'b1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (gnt == '0 && c < 500);
            chk("contention_gnt_seen", 32'(gnt != '0), 1);
        end
        req = '0;
        drain();

        // Back-to-back: rr=1; req1 re-raised with its rsp_valid while req3 waits
        set_fields(1, 1'b0, 7'h31, 12'h311);
        set_fields(3, 1'b0, 7'h33, 12'h333);
        push_txn(1, 1'b0, 7'h31, 12'h311, 1'b0, 12'hDEF, 1'b1, 1'b1);
        push_txn(3, 1'b0, 7'h33, 12'h333, 1'b0, 12'hDEF, 1'b1, 1'b1);
        push_txn(1, 1'b0, 7'h31, 12'h311, 1'b0, 12'hDEF, 1'b1, 1'b1);
        req[1] = 1'b1;
        wait_gnt(1, lat);
        req[1] = 1'b0;
        req[3] = 1'b1;
        wait_rsp(1);
        req[1] = 1'b1;
        wait_gnt(3, lat);
        req[3] = 1'b0;
        wait_gnt(1, lat);
        req[1] = 1'b0;
        drain();

        // Start timeout: master never goes busy
        dead = 1'b1;
        set_fields(2, 1'b0, 7'h44, 12'h444);
        push_txn(2, 1'b0, 7'h44, 12'h444, 1'b1, 12'hDEF, 1'b0, 1'b1);
        req[2] = 1'b1;
        wait_gnt(2, lat);
        req[2] = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 200 && !rsp_valid[2]; c++) begin
            @(negedge clk);
            if (m_enable) en_cnt++;
        end
        chk("start_timeout_enable_cycles", 32'(en_cnt), 16);
        drain();
        dead = 1'b0;
        single(0, 1'b0, 7'h55, 12'h555, 1'b0, 12'hDEF, 1'b1);
        drain();

        // Reset mid-RUN with the master hung busy
        hang = 1'b1;
        set_fields(1, 1'b1, 7'h66, 12'h666);
        push_txn(1, 1'b1, 7'h66, 12'h666, 1'b0, 12'h000, 1'b1, 1'b0);
        req[1] = 1'b1;
        wait_gnt(1, lat);
        req[1] = 1'b0;
        for (int c = 0; c < 200 && !m_busy; c++) @(negedge clk);
        chk("hang_busy_seen", 32'(m_busy), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_m_enable", 32'(m_enable), 0);
        chk("midrun_rst_fields", {m_rw, m_slave_addr, m_data_in}, 0);
        chk("midrun_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("midrun_rst_gnt", 32'(gnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        single(0, 1'b0, 7'h77, 12'h777, 1'b0, 12'h000, 1'b1);
        repeat (8) @(negedge clk);
        chk("wait_free_hold_enable", 32'(m_enable), 0);
        hang = 1'b0;
        hang_release = 1'b1;
        drain();

        chk("gnt_queue_empty", 32'(exp_gnt.size()), 0);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);
        chk("launch_queue_empty", 32'(exp_launch.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
